// File: rtl/shape_pkg.sv
// Shared types and constants for the shape editor.
//
// Contents:
//   INT_BITS / FLOAT_BITS / FRAC_BITS / PIXLW : datapath widths. Trig values are
//                                               signed fixed point, FRAC_BITS
//                                               fractional bits.
//   SHP_X0 / SHP_Y0 : default screen centre, which is the reset position on an
//                     800x600 screen.
//   SHP_SIZE0       : reset size of a slot.
//   COS_ONE         : 1.0 in trig fixed point.
//   shape_t         : one shape slot.
//   edit_mode_t     : meaning of the 2-bit mode input.
//   ed_state_t      : editor FSM states.
//   shape_reset()   : builds a freshly initialised slot.
package shape_pkg;

  localparam int INT_BITS   = 16;
  localparam int FLOAT_BITS = 16;
  localparam int FRAC_BITS  = 14;
  localparam int PIXLW      = 12;

  localparam logic [INT_BITS-1:0]          SHP_X0    = 16'd400;
  localparam logic [INT_BITS-1:0]          SHP_Y0    = 16'd300;
  localparam logic [INT_BITS-1:0]          SHP_SIZE0 = 16'd10;
  localparam logic signed [FLOAT_BITS-1:0] COS_ONE   = 16'sd16384;
  localparam logic [PIXLW-1:0]             COLOR_ON  = 12'hFFF;

  typedef struct packed {
    logic [INT_BITS-1:0]          x;
    logic [INT_BITS-1:0]          y;
    logic [INT_BITS-1:0]          size;
    logic [INT_BITS-1:0]          ty;
    logic signed [INT_BITS-1:0]   angle;
    logic signed [FLOAT_BITS-1:0] sin;
    logic signed [FLOAT_BITS-1:0] cos;
    logic [PIXLW-1:0]             color;
  } shape_t;

  typedef enum logic [1:0] {
    MODE_MOVE  = 2'd0,
    MODE_SHAPE = 2'd1,
    MODE_LIST  = 2'd2,
    MODE_COLOR = 2'd3
  } edit_mode_t;

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    IDLE   = 3'd1,
    APPLY  = 3'd2,
    TRIG_W = 3'd3,
    TRIG_R = 3'd4,
    DONE   = 3'd5
  } ed_state_t;

  function automatic shape_t shape_reset(input logic [INT_BITS-1:0] x0,
                                         input logic [INT_BITS-1:0] y0,
                                         input logic [PIXLW-1:0]    color);
    shape_t s;
    s.x     = x0;
    s.y     = y0;
    s.size  = SHP_SIZE0;
    s.ty    = '0;
    s.angle = '0;
    s.sin   = '0;
    s.cos   = COS_ONE;
    s.color = color;
    return s;
  endfunction

endpackage

// File: rtl/sat_step.sv
// Adds a signed delta to a value and bounds the result to [lo, hi].
// With wrap=0 the result clamps at the bound it crossed; with wrap=1 it folds
// around the range (hi+1 -> lo, lo-1 -> hi). A single fold is enough because
// callers never step by more than one full range.
//
// Ports:
//   val   in  W signed   current value (assumed inside [lo, hi])
//   delta in  W signed   step to apply
//   lo    in  W signed   lower bound
//   hi    in  W signed   upper bound
//   wrap  in  1          1 = circular, 0 = saturating
//   res   out W signed   bounded result
module sat_step #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] val,
  input  logic signed [W-1:0] delta,
  input  logic signed [W-1:0] lo,
  input  logic signed [W-1:0] hi,
  input  logic                wrap,
  output logic signed [W-1:0] res
);

  // Two guard bits so the raw sum and the folded sum can never overflow.
  logic signed [W+1:0] sum;
  logic signed [W+1:0] lo_e;
  logic signed [W+1:0] hi_e;
  logic signed [W+1:0] span;
  logic signed [W+1:0] folded;

  always_comb begin
    sum    = {{2{val[W-1]}}, val} + {{2{delta[W-1]}}, delta};
    lo_e   = {{2{lo[W-1]}}, lo};
    hi_e   = {{2{hi[W-1]}}, hi};
    span   = hi_e - lo_e + (W+2)'(1);
    folded = sum;
    res    = sum[W-1:0];
    if (sum > hi_e) begin
      folded = sum - span;
      res    = wrap ? folded[W-1:0] : hi;
    end else if (sum < lo_e) begin
      folded = sum + span;
      res    = wrap ? folded[W-1:0] : lo;
    end
  end

endmodule

// File: rtl/shape_editor.sv
// Per-frame shape property controller.
//
// Holds position, size, angle, type, colour and cached sin/cos for MAXSHP
// shape slots. On each start-of-frame pulse it applies one edit step to the
// selected slot according to mode and the button pulses, pulses done, then
// walks every slot through the external combinational trig unit to refresh
// the cached sin/cos.
//
// Optional build macro SHAPE_EDIT_ACCEL_EN: when defined, btn_mag scales the
// edit step (1,2,4,8 for x/y/size, ANG_STEP<<btn_mag for rotation). When not
// defined btn_mag is ignored.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   frame                        start-of-frame pulse
//   mode[1:0]                    0 move, 1 size/rotate/type, 2 add/remove/select, 3 colour
//   btn_l/r/u/d                  held (repeat-capable) button pulses
//   btn_c_once/l_once/r_once     single-shot button pulses
//   btn_mag[1:0]                 step magnitude (accel build only)
//   pick_color                   colour under the picker cursor
//   trig_angle                   angle presented to the trig unit
//   trig_sin, trig_cos           trig unit result for trig_angle
//   s_x, s_y, s_size, s_ty,
//   s_angle, s_sin, s_cos,
//   s_color                      per-slot properties
//   count, sel                   active slot count, selected slot
//   done                         one-cycle pulse per frame update
//   overrun                      sticky: frame seen while busy
module shape_editor
  import shape_pkg::*;
#(
  parameter int MAXSHP   = 4,
  parameter int SCR_W    = 800,
  parameter int SCR_H    = 600,
  parameter int SIZE_MAX = 255,
  parameter int ANG_STEP = 1,
  parameter int NTYPE    = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                frame,
  input  logic [1:0]                          mode,
  input  logic                                btn_l,
  input  logic                                btn_r,
  input  logic                                btn_u,
  input  logic                                btn_d,
  input  logic                                btn_c_once,
  input  logic                                btn_l_once,
  input  logic                                btn_r_once,
  input  logic [1:0]                          btn_mag,
  input  logic [PIXLW-1:0]                    pick_color,
  output logic [INT_BITS-1:0]                 trig_angle,
  input  logic signed [FLOAT_BITS-1:0]        trig_sin,
  input  logic signed [FLOAT_BITS-1:0]        trig_cos,
  output logic [MAXSHP-1:0][INT_BITS-1:0]     s_x,
  output logic [MAXSHP-1:0][INT_BITS-1:0]     s_y,
  output logic [MAXSHP-1:0][INT_BITS-1:0]     s_size,
  output logic [MAXSHP-1:0][INT_BITS-1:0]     s_ty,
  output logic [MAXSHP-1:0][INT_BITS-1:0]     s_angle,
  output logic [MAXSHP-1:0][FLOAT_BITS-1:0]   s_sin,
  output logic [MAXSHP-1:0][FLOAT_BITS-1:0]   s_cos,
  output logic [MAXSHP-1:0][PIXLW-1:0]        s_color,
  output logic [INT_BITS-1:0]                 count,
  output logic [INT_BITS-1:0]                 sel,
  output logic                                done,
  output logic                                overrun
);

  localparam int IDXW = (MAXSHP > 1) ? $clog2(MAXSHP) : 1;

  localparam logic [INT_BITS-1:0]        X0      = INT_BITS'(SCR_W / 2);
  localparam logic [INT_BITS-1:0]        Y0      = INT_BITS'(SCR_H / 2);
  localparam logic signed [INT_BITS-1:0] X_HI    = INT_BITS'(SCR_W - 1);
  localparam logic signed [INT_BITS-1:0] Y_HI    = INT_BITS'(SCR_H - 1);
  localparam logic signed [INT_BITS-1:0] SZ_HI   = INT_BITS'(SIZE_MAX);
  localparam logic signed [INT_BITS-1:0] ANG_LO  = INT_BITS'(-180);
  localparam logic signed [INT_BITS-1:0] ANG_HI  = INT_BITS'(179);
  localparam logic [INT_BITS-1:0]        TY_HI   = INT_BITS'(NTYPE - 1);
  localparam logic [INT_BITS-1:0]        CNT_MAX = INT_BITS'(MAXSHP);
  localparam logic [INT_BITS-1:0]        K_LAST  = INT_BITS'(MAXSHP - 1);
  localparam logic [INT_BITS-1:0]        ONE     = INT_BITS'(1);

  ed_state_t  state;
  ed_state_t  state_nx;
  edit_mode_t emode;

  shape_t shp [MAXSHP];
  shape_t cur;

  logic [INT_BITS-1:0] k;
  logic [INT_BITS-1:0] cnt_m1;
  logic [IDXW-1:0]     si;
  logic [IDXW-1:0]     ki;
  logic [IDXW-1:0]     ci;
  logic [IDXW-1:0]     cmi;

  logic signed [INT_BITS-1:0] step;
  logic signed [INT_BITS-1:0] rstep;
  logic signed [INT_BITS-1:0] dx;
  logic signed [INT_BITS-1:0] dy;
  logic signed [INT_BITS-1:0] dsz;
  logic signed [INT_BITS-1:0] dang;
  logic signed [INT_BITS-1:0] nx;
  logic signed [INT_BITS-1:0] ny;
  logic signed [INT_BITS-1:0] nsz;
  logic signed [INT_BITS-1:0] nang;

  assign emode  = edit_mode_t'(mode);
  assign cnt_m1 = count - ONE;
  assign si     = sel[IDXW-1:0];
  assign ki     = k[IDXW-1:0];
  assign ci     = count[IDXW-1:0];
  assign cmi    = cnt_m1[IDXW-1:0];
  assign cur    = shp[si];

`ifdef SHAPE_EDIT_ACCEL_EN
  assign step  = ONE << btn_mag;
  assign rstep = INT_BITS'(ANG_STEP) << btn_mag;
`else
  logic unused_mag;
  assign unused_mag = ^btn_mag;
  assign step       = ONE;
  assign rstep      = INT_BITS'(ANG_STEP);
`endif

  // Deltas are zero unless the current mode uses that field, so the bounded
  // results below can be written back unconditionally during APPLY.
  always_comb begin
    dx   = '0;
    dy   = '0;
    dsz  = '0;
    dang = '0;
    case (emode)
      MODE_MOVE: begin
        if (btn_u)      dy = -step;
        else if (btn_d) dy = step;
        if (btn_l)      dx = -step;
        else if (btn_r) dx = step;
      end
      MODE_SHAPE: begin
        if (btn_l)      dang = -rstep;
        else if (btn_r) dang = rstep;
        if (btn_u)      dsz = step;
        else if (btn_d) dsz = -step;
      end
      default: ;
    endcase
  end

  sat_step #(.W(INT_BITS)) u_step_x (
    .val(cur.x), .delta(dx), .lo('0), .hi(X_HI), .wrap(1'b0), .res(nx)
  );

  sat_step #(.W(INT_BITS)) u_step_y (
    .val(cur.y), .delta(dy), .lo('0), .hi(Y_HI), .wrap(1'b0), .res(ny)
  );

  sat_step #(.W(INT_BITS)) u_step_size (
    .val(cur.size), .delta(dsz), .lo('0), .hi(SZ_HI), .wrap(1'b0), .res(nsz)
  );

  sat_step #(.W(INT_BITS)) u_step_angle (
    .val(cur.angle), .delta(dang), .lo(ANG_LO), .hi(ANG_HI), .wrap(1'b1), .res(nang)
  );

  // FSM state register and sticky overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= INIT;
      overrun <= 1'b0;
    end else begin
      state <= state_nx;
      if (frame && (state != IDLE)) overrun <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    done     = 1'b0;
    case (state)
      INIT:   state_nx = DONE;
      IDLE:   if (frame) state_nx = APPLY;
      APPLY:  state_nx = DONE;
      DONE: begin
        state_nx = TRIG_W;
        done     = 1'b1;
      end
      TRIG_W: state_nx = TRIG_R;
      TRIG_R: state_nx = (k == K_LAST) ? IDLE : TRIG_W;
      default: state_nx = INIT;
    endcase
  end

  // Shape storage. Reinitialised both on the reset edge itself and in INIT so
  // the defaults are visible the cycle after rst is seen.
  always_ff @(posedge clk) begin
    if (rst || (state == INIT)) begin
      for (int i = 0; i < MAXSHP; i++) begin
        shp[i] <= shape_reset(X0, Y0, '0);
      end
      shp[0].color <= COLOR_ON;
      count        <= ONE;
      sel          <= '0;
      k            <= '0;
    end else begin
      case (state)
        APPLY: begin
          shp[si].x     <= nx;
          shp[si].y     <= ny;
          shp[si].size  <= nsz;
          shp[si].angle <= nang;
          case (emode)
            MODE_SHAPE: begin
              if (btn_c_once) shp[si].ty <= (cur.ty >= TY_HI) ? '0 : cur.ty + ONE;
            end
            MODE_LIST: begin
              // Add beats remove beats select.
              if (btn_r_once && (count < CNT_MAX)) begin
                shp[ci] <= shape_reset(X0, Y0, COLOR_ON);
                count   <= count + ONE;
                sel     <= count;
              end else if (btn_l_once && (count > ONE)) begin
                shp[cmi].color <= '0;
                count          <= cnt_m1;
                if (sel >= cnt_m1) sel <= cnt_m1 - ONE;
              end else if (btn_c_once) begin
                sel <= (sel >= cnt_m1) ? '0 : sel + ONE;
              end
            end
            MODE_COLOR: begin
              if (btn_c_once) shp[si].color <= pick_color;
            end
            default: ;
          endcase
        end
        DONE: k <= '0;
        TRIG_R: begin
          shp[ki].sin <= trig_sin;
          shp[ki].cos <= trig_cos;
          k           <= (k == K_LAST) ? '0 : k + ONE;
        end
        default: ;
      endcase
    end
  end

  assign trig_angle = shp[ki].angle;

  always_comb begin
    for (int i = 0; i < MAXSHP; i++) begin
      s_x[i]     = shp[i].x;
      s_y[i]     = shp[i].y;
      s_size[i]  = shp[i].size;
      s_ty[i]    = shp[i].ty;
      s_angle[i] = shp[i].angle;
      s_sin[i]   = shp[i].sin;
      s_cos[i]   = shp[i].cos;
      s_color[i] = shp[i].color;
    end
  end

endmodule

// File: tb/tb_shape_editor.sv
module tb_shape_editor;
  import shape_pkg::*;

  localparam int MAXSHP = 4;

  logic clk;
  logic rst;
  logic frame;
  logic [1:0] mode;
  logic btn_l, btn_r, btn_u, btn_d;
  logic btn_c_once, btn_l_once, btn_r_once;
  logic [1:0] btn_mag;
  logic [11:0] pick_color;
  logic [15:0] trig_angle;
  logic signed [15:0] trig_sin, trig_cos;
  logic [MAXSHP-1:0][15:0] s_x, s_y, s_size, s_ty, s_angle, s_sin, s_cos;
  logic [MAXSHP-1:0][11:0] s_color;
  logic [15:0] count, sel;
  logic done, overrun;

  int total = 0;
  int bad   = 0;

  // reference model of the slot table
  int mx[MAXSHP], my[MAXSHP], msz[MAXSHP], mty[MAXSHP], mang[MAXSHP];
  int msin[MAXSHP], mcos[MAXSHP], mcol[MAXSHP];
  int mcount, msel;

  shape_editor #(.MAXSHP(MAXSHP)) dut (
    .clk(clk), .rst(rst), .frame(frame), .mode(mode),
    .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u), .btn_d(btn_d),
    .btn_c_once(btn_c_once), .btn_l_once(btn_l_once), .btn_r_once(btn_r_once),
    .btn_mag(btn_mag), .pick_color(pick_color),
    .trig_angle(trig_angle), .trig_sin(trig_sin), .trig_cos(trig_cos),
    .s_x(s_x), .s_y(s_y), .s_size(s_size), .s_ty(s_ty), .s_angle(s_angle),
    .s_sin(s_sin), .s_cos(s_cos), .s_color(s_color),
    .count(count), .sel(sel), .done(done), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic signed [15:0] tsin(input int a);
    real r;
    r = real'(a) * 3.14159265358979 / 180.0;
    return 16'($rtoi($sin(r) * 16384.0));
  endfunction

  function automatic logic signed [15:0] tcos(input int a);
    real r;
    r = real'(a) * 3.14159265358979 / 180.0;
    return 16'($rtoi($cos(r) * 16384.0));
  endfunction

  // combinational trig unit
  assign trig_sin = tsin(int'($signed(trig_angle)));
  assign trig_cos = tcos(int'($signed(trig_angle)));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < MAXSHP; i++) begin
      mx[i] = 400; my[i] = 300; msz[i] = 10; mty[i] = 0; mang[i] = 0;
      msin[i] = 0; mcos[i] = 16384; mcol[i] = 0;
    end
    mcol[0] = 12'hFFF;
    mcount = 1;
    msel = 0;
  endtask

  task automatic model_refresh();
    for (int i = 0; i < MAXSHP; i++) begin
      msin[i] = int'(tsin(mang[i]));
      mcos[i] = int'(tcos(mang[i]));
    end
  endtask

  task automatic model_apply(input int md, input bit l, r, u, d, c1, l1, r1,
                             input int mag, input int pick);
    int st, rs, s;
`ifdef SHAPE_EDIT_ACCEL_EN
    st = 1 << mag;
    rs = 1 << mag;
`else
    st = 1;
    rs = 1;
`endif
    s = msel;
    case (md)
      0: begin
        if (u)      my[s] = (my[s] - st < 0) ? 0 : my[s] - st;
        else if (d) my[s] = (my[s] + st > 599) ? 599 : my[s] + st;
        if (l)      mx[s] = (mx[s] - st < 0) ? 0 : mx[s] - st;
        else if (r) mx[s] = (mx[s] + st > 799) ? 799 : mx[s] + st;
      end
      1: begin
        if (l)      mang[s] = mang[s] - rs;
        else if (r) mang[s] = mang[s] + rs;
        if (mang[s] > 179)  mang[s] = mang[s] - 360;
        if (mang[s] < -180) mang[s] = mang[s] + 360;
        if (u)      msz[s] = (msz[s] + st > 255) ? 255 : msz[s] + st;
        else if (d) msz[s] = (msz[s] - st < 0) ? 0 : msz[s] - st;
        if (c1) mty[s] = (mty[s] + 1) % 4;
      end
      2: begin
        if (r1 && mcount < MAXSHP) begin
          mx[mcount] = 400; my[mcount] = 300; msz[mcount] = 10; mty[mcount] = 0;
          mang[mcount] = 0; mcol[mcount] = 12'hFFF;
          msel = mcount;
          mcount++;
        end else if (l1 && mcount > 1) begin
          mcount--;
          mcol[mcount] = 0;
          if (msel >= mcount) msel = mcount - 1;
        end else if (c1) begin
          msel = (msel + 1) % mcount;
        end
      end
      default: if (c1) mcol[s] = pick;
    endcase
  endtask

  // One full frame: pulse frame, hold the buttons through APPLY, wait for
  // done, let the refresh run out, then advance the model.
  task automatic run_frame(input int md, input bit l, r, u, d, c1, l1, r1,
                           input int mag, input int pick);
    int n;
    mode = 2'(md); btn_l = l; btn_r = r; btn_u = u; btn_d = d;
    btn_c_once = c1; btn_l_once = l1; btn_r_once = r1;
    btn_mag = 2'(mag); pick_color = 12'(pick);
    frame = 1'b1;
    tick();
    frame = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 4) begin
      tick();
      n++;
    end
    if (done !== 1'b1) begin
      total++; bad++;
      $display("FAIL frame_done_timeout: done=%b required 1", done);
    end
    btn_l = 0; btn_r = 0; btn_u = 0; btn_d = 0;
    btn_c_once = 0; btn_l_once = 0; btn_r_once = 0;
    repeat (2 * MAXSHP + 1) tick();
    model_apply(md, l, r, u, d, c1, l1, r1, mag, pick);
    model_refresh();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    total++; if (s_x[0] !== 16'd400) begin bad++; $display("FAIL rst_x0: got %0d want 400", s_x[0]); end
    total++; if (s_y[0] !== 16'd300) begin bad++; $display("FAIL rst_y0: got %0d want 300", s_y[0]); end
    total++; if (count !== 16'd1) begin bad++; $display("FAIL rst_count: got %0d want 1", count); end
    total++; if (sel !== 16'd0) begin bad++; $display("FAIL rst_sel: got %0d want 0", sel); end
    total++; if (s_cos[0] !== 16'd16384) begin bad++; $display("FAIL rst_cos0: got %0d want 16384", s_cos[0]); end
    total++; if (s_color[0] !== 12'hFFF || s_color[1] !== 12'h000) begin
      bad++; $display("FAIL rst_color: got %h/%h want fff/000", s_color[0], s_color[1]);
    end
    total++; if (done !== 1'b0 || overrun !== 1'b0) begin
      bad++; $display("FAIL rst_flags: done=%b overrun=%b want 0/0", done, overrun);
    end
    rst = 1'b0;
    tick();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL init_done: got %b want 1", done); end
    repeat (2 * MAXSHP + 1) tick();
    model_reset();
    model_refresh();
    // frame -> done latency
    frame = 1'b1;
    tick();
    frame = 1'b0;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL lat_apply: done=%b want 0", done); end
    tick();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL lat_done: done=%b want 1", done); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL lat_pulse: done=%b want 0", done); end
    repeat (2 * MAXSHP) tick();
  endtask

  task automatic test_move();
    for (int f = 0; f < 405; f++) begin
      run_frame(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      if (f == 399) begin
        total++; if (s_x[0] !== 16'd0) begin bad++; $display("FAIL move_x_400: got %0d want 0", s_x[0]); end
      end
      if (f == 398) begin
        total++; if (s_x[0] !== 16'd1) begin bad++; $display("FAIL move_x_399: got %0d want 1", s_x[0]); end
      end
    end
    total++; if (s_x[0] !== 16'(mx[0]) || mx[0] != 0) begin
      bad++; $display("FAIL move_x_held: got %0d want 0", s_x[0]);
    end
    total++; if (s_y[0] !== 16'd300) begin bad++; $display("FAIL move_y: got %0d want 300", s_y[0]); end
  endtask

  task automatic test_rotate();
    for (int f = 0; f < 179; f++) run_frame(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    total++; if ($signed(s_angle[0]) !== 16'sd179) begin
      bad++; $display("FAIL rot_179: got %0d want 179", $signed(s_angle[0]));
    end
    run_frame(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    total++; if ($signed(s_angle[0]) !== -16'sd180) begin
      bad++; $display("FAIL rot_wrap_hi: got %0d want -180", $signed(s_angle[0]));
    end
    total++; if (s_sin[0] !== tsin(-180) || s_cos[0] !== tcos(-180)) begin
      bad++; $display("FAIL rot_trig: got %0d/%0d want %0d/%0d", $signed(s_sin[0]),
                      $signed(s_cos[0]), tsin(-180), tcos(-180));
    end
    run_frame(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    total++; if ($signed(s_angle[0]) !== 16'sd179) begin
      bad++; $display("FAIL rot_wrap_lo: got %0d want 179", $signed(s_angle[0]));
    end
    total++; if (s_sin[0] !== tsin(179)) begin
      bad++; $display("FAIL rot_sin179: got %0d want %0d", $signed(s_sin[0]), tsin(179));
    end
  endtask

  task automatic test_list();
    int exp_cnt[4];
    exp_cnt = '{2, 3, 4, 4};
    for (int f = 0; f < 4; f++) begin
      run_frame(2, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      total++; if (count !== 16'(exp_cnt[f])) begin
        bad++; $display("FAIL add_count[%0d]: got %0d want %0d", f, count, exp_cnt[f]);
      end
    end
    total++; if (sel !== 16'd3) begin bad++; $display("FAIL add_sel: got %0d want 3", sel); end
    total++; if (s_color[3] !== 12'hFFF || s_x[3] !== 16'd400) begin
      bad++; $display("FAIL add_slot3: color %h x %0d want fff 400", s_color[3], s_x[3]);
    end
    run_frame(2, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    total++; if (count !== 16'd3 || sel !== 16'd2) begin
      bad++; $display("FAIL remove: count %0d sel %0d want 3 2", count, sel);
    end
    total++; if (s_color[3] !== 12'h000) begin
      bad++; $display("FAIL remove_color: got %h want 000", s_color[3]);
    end
  endtask

  task automatic test_color();
    run_frame(2, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    total++; if (sel !== 16'd0) begin bad++; $display("FAIL sel_wrap: got %0d want 0", sel); end
    run_frame(2, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    total++; if (sel !== 16'd1) begin bad++; $display("FAIL sel_next: got %0d want 1", sel); end
    run_frame(3, 0, 0, 0, 0, 1, 0, 0, 0, 12'h0F0);
    total++; if (s_color[1] !== 12'h0F0) begin
      bad++; $display("FAIL color_apply: got %h want 0f0", s_color[1]);
    end
    total++; if (s_color[0] !== 12'hFFF) begin
      bad++; $display("FAIL color_other: got %h want fff", s_color[0]);
    end
  endtask

  task automatic test_overrun();
    frame = 1'b1;
    tick();
    frame = 1'b0;
    tick();
    tick();
    frame = 1'b1;
    tick();
    frame = 1'b0;
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_set: got %b want 1", overrun); end
    tick();
    total++; if (overrun !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL overrun_sticky: overrun %b done %b want 1 0", overrun, done);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL overrun_clr: got %b want 0", overrun); end
    total++; if (s_x[0] !== 16'd400 || count !== 16'd1 || sel !== 16'd0) begin
      bad++; $display("FAIL midrst_vals: x %0d count %0d sel %0d want 400 1 0", s_x[0], count, sel);
    end
    total++; if (s_color[1] !== 12'h000 || $signed(s_angle[0]) !== 16'sd0) begin
      bad++; $display("FAIL midrst_slot: color1 %h angle0 %0d want 000 0", s_color[1], $signed(s_angle[0]));
    end
    repeat (2 * MAXSHP + 4) tick();
    model_reset();
    model_refresh();
  endtask

  task automatic test_random();
    int md, mg, pk;
    bit l, r, u, d, c1, l1, r1;
    for (int f = 0; f < 120; f++) begin
      md = int'($urandom_range(0, 3));
      l = 1'($urandom); r = 1'($urandom); u = 1'($urandom); d = 1'($urandom);
      c1 = 1'($urandom); l1 = 1'($urandom); r1 = 1'($urandom);
      mg = int'($urandom_range(0, 3));
      pk = int'($urandom_range(0, 4095));
      run_frame(md, l, r, u, d, c1, l1, r1, mg, pk);
      total++; if (count !== 16'(mcount) || sel !== 16'(msel)) begin
        bad++; $display("FAIL rnd_list f%0d: count %0d sel %0d want %0d %0d", f, count, sel, mcount, msel);
      end
      for (int i = 0; i < MAXSHP; i++) begin
        total++;
        if (s_x[i] !== 16'(mx[i]) || s_y[i] !== 16'(my[i]) || s_size[i] !== 16'(msz[i]) ||
            s_ty[i] !== 16'(mty[i]) || s_angle[i] !== 16'(mang[i])) begin
          bad++;
          $display("FAIL rnd_geom f%0d s%0d: x%0d y%0d sz%0d ty%0d a%0d want x%0d y%0d sz%0d ty%0d a%0d",
                   f, i, s_x[i], s_y[i], s_size[i], s_ty[i], $signed(s_angle[i]),
                   mx[i], my[i], msz[i], mty[i], mang[i]);
        end
        total++;
        if (s_sin[i] !== 16'(msin[i]) || s_cos[i] !== 16'(mcos[i]) || s_color[i] !== 12'(mcol[i])) begin
          bad++;
          $display("FAIL rnd_attr f%0d s%0d: sin%0d cos%0d col%h want sin%0d cos%0d col%h",
                   f, i, $signed(s_sin[i]), $signed(s_cos[i]), s_color[i], msin[i], mcos[i], mcol[i]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; frame = 1'b0; mode = 2'd0;
    btn_l = 0; btn_r = 0; btn_u = 0; btn_d = 0;
    btn_c_once = 0; btn_l_once = 0; btn_r_once = 0;
    btn_mag = 2'd0; pick_color = 12'h000;
    test_reset();
    test_move();
    test_rotate();
    test_list();
    test_color();
    test_overrun();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shape_editor.md
Name: shape_editor

Overview:
- Per-frame shape-property controller: owns position, size, angle, type, colour and cached sin/cos for up to MAXSHP shapes.
- Edits the currently selected shape, not a fixed shape 0.
- Sits between the input_mode button conditioners and the render_shape array.
- Once per frame it applies one edit step, then refreshes sin/cos for every shape through an external trig unit (cos_deg/sin_deg).

Parameters:
- MAXSHP, 4, number of shape slots (2..16).
- SCR_W, 800, screen width; x clamps to 0..SCR_W-1.
- SCR_H, 600, screen height; y clamps to 0..SCR_H-1.
- SIZE_MAX, 255, maximum size.
- ANG_STEP, 1, degrees per rotate step.
- NTYPE, 4, number of shape types; ty wraps 0..NTYPE-1.
- PIXLW, 12, colour width.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous reset, active-high.
- frame  in  1  start-of-frame pulse from vga timing.
- mode  in  2  0 move, 1 resize/rotate/type, 2 add/remove/select, 3 colour apply.
- btn_l, btn_r, btn_u, btn_d  in  1 each  repeat-capable held pulses.
- btn_c_once, btn_l_once, btn_r_once  in  1 each  single-shot pulses.
- btn_mag  in  2  magnitude from input_mode.
- pick_color  in  PIXLW  colour under the picker cursor.
- trig_angle  out  INT_BITS  angle presented to the trig unit.
- trig_sin, trig_cos  in  FLOAT_BITS signed each  combinational result for trig_angle.
- s_x, s_y, s_size, s_ty, s_angle  out  MAXSHP x INT_BITS  per-shape properties.
- s_sin, s_cos  out  MAXSHP x FLOAT_BITS  cached trig values.
- s_color  out  MAXSHP x PIXLW  per-shape colour.
- count  out  INT_BITS  active shapes.
- sel  out  INT_BITS  selected shape.
- done  out  1  one-cycle pulse per completed frame update (drives input_mode clr).
- overrun  out  1  sticky; set when frame arrives while busy.

Behaviour:
- FSM states: INIT, IDLE, APPLY, TRIG_W, TRIG_R, DONE.
  - INIT -> DONE.
  - IDLE -> APPLY on frame.
  - APPLY -> DONE.
  - DONE -> TRIG_W with trig index k=0.
  - TRIG_W -> TRIG_R.
  - TRIG_R -> TRIG_W, or -> IDLE when k==MAXSHP-1.
- Reset values (rst seen at any state forces INIT next cycle; all registers reinitialised in INIT):
  - Every slot: x=SCR_W/2, y=SCR_H/2, size=10, ty=0, angle=0, sin=0, cos=1.0 fixed-point, color=0.
  - Slot 0 color=12'hFFF.
  - count=1, sel=0, k=0, done=0, overrun=0.
- done is high exactly in DONE.
  - Latency frame -> done: 3 cycles (frame, APPLY, DONE).
  - Full refresh ends 2*MAXSHP cycles after done.
- APPLY acts on slot sel only, with step = 1.
- Mode 0:
  - btn_u / btn_d: y -/+ step, saturating at 0 and SCR_H-1; u has priority over d.
  - btn_l / btn_r: x -/+ step, saturating at 0 and SCR_W-1; l has priority over r.
- Mode 1:
  - btn_l / btn_r rotate by -/+ANG_STEP, circular in -180..179 (179+1 -> -180, -180-1 -> 179).
  - btn_u / btn_d: size +/- step, saturating 0..SIZE_MAX.
  - btn_c_once: ty+1, wrapping NTYPE-1 -> 0.
- Mode 2 (priority order r_once > l_once > c_once):
  - r_once with count<MAXSHP: slot[count] gets reset values with color 12'hFFF; count+1; sel=new slot.
  - l_once with count>1: slot[count-1] color=0; count-1; if sel>=new count then sel=new count-1.
  - c_once: sel+1, wrapping count-1 -> 0.
- Mode 3: btn_c_once -> s_color[sel]=pick_color.
- Refresh phase:
  - TRIG_W: trig_angle=s_angle[k].
  - TRIG_R: s_sin[k], s_cos[k] captured; k wraps to 0.
  - Inactive slots are refreshed too (harmless).
- Frame handling:
  - frame in any state other than IDLE is dropped and sets overrun.
  - overrun is cleared only by rst.
- Mode changes take effect at the next APPLY; no edits outside APPLY.

Optional Feature:
- SHAPE_EDIT_ACCEL_EN.
- Defined: step = 1<<btn_mag (1,2,4,8) for x, y, size; rotate step = ANG_STEP<<btn_mag; saturation still exact (clamp, never overshoot).
- Undefined: btn_mag ignored; step fixed at 1 and ANG_STEP.

Decomposition:
- Package shape_pkg holds:
  - shape_t struct: x, y, size, ty, angle, sin, cos, color.
  - edit_mode_t enum.
  - editor state enum.
  - Reset-value constants SHP_X0, SHP_Y0, SHP_SIZE0, COS_ONE.
- One sub-module, sat_step: saturating/circular add of signed delta with lo/hi bounds and a wrap flag; used for x, y, size and angle.

Test Plan:
- Reset, then frame: done pulses 3 cycles later; s_x[0]=400, s_y[0]=300, count=1, sel=0, s_cos[0]=COS_ONE.
- Mode 0, btn_l held 405 frames from x=400: x reaches 0 after 400 frames and stays 0; s_y unchanged.
- Mode 1, angle=179, btn_r one frame -> angle=-180 and s_sin/s_cos match trig of -180 after refresh; btn_l -> 179.
- Mode 2, r_once x4 with MAXSHP=4: count goes 2,3,4,4; sel=3. Then sel=3 and l_once -> count=3, sel=2, s_color[3]=0.
- Mode 3, sel=1, pick_color=12'h0F0, btn_c_once -> s_color[1]=12'h0F0, s_color[0] unchanged.
- Frame pulse during TRIG_W -> ignored, overrun=1. rst mid-refresh -> INIT values restored next cycle, overrun=0.
